// File: rtl/gpio_pad_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_pad_ctrl_if
// Purpose : single-cycle register port between the SoC peripheral bus and the
//           GPIO controller.
// Signals : wr_en    - one-cycle write strobe
//           rd_en    - one-cycle read strobe
//           addr     - 3-bit register address
//           wr_data  - 32-bit write data
//           rd_data  - 32-bit read data, held until the next read
//           rd_valid - one-cycle pulse, rd_data valid
// Modports: master (bus side), slave (register block side)
// ---------------------------------------------------------------------------
interface gpio_pad_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_pad_ctrl
// Purpose : fabric-side GPIO controller for a bank of bidirectional pad
//           wrappers. Provides OUT/OE/IN registers, rising-edge capture
//           (W1C status) with a mask and a registered level interrupt.
// Ports   : clk      - system clock
//           reset_   - asynchronous active-low reset
//           bus      - register port (gpio_pad_ctrl_if.slave)
//           irq      - level interrupt, |(RISE_STS & RISE_MASK), registered
//           pad_ena  - per-bit output enable to the pads (OE register)
//           to_pad   - per-bit output value to the pads (OUT register)
//           from_pad - per-bit raw asynchronous pad input
// Register map: 0 OUT (RW), 1 OE (RW), 2 IN (RO), 3 RISE_STS (W1C),
//               4 RISE_MASK (RW), 5..7 read 0 / writes ignored.
// Optional : define GPIO_DEBOUNCE_EN to insert a per-bit debounce counter
//            between the synchronizer and IN (DEBOUNCE_CYCLES stable cycles).
// ---------------------------------------------------------------------------
module gpio_pad_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    gpio_pad_ctrl_if.slave       bus,
    output logic                 irq,
    output logic [WIDTH-1:0]     pad_ena,
    output logic [WIDTH-1:0]     to_pad,
    input  logic [WIDTH-1:0]     from_pad
);

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
        $error("gpio_pad_ctrl: WIDTH or DEBOUNCE_CYCLES out of range");
    end

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_STS  = 3'd3;
    localparam logic [2:0] ADDR_MASK = 3'd4;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] oe_reg;
    logic [WIDTH-1:0] sts_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sts_clr;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [1:0]       sync_vld;
    logic [WIDTH-1:0] in_val;
    logic             in_valid;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [WIDTH-1:0] rise;
    logic             unused_wr_data;

    // Bits of wr_data above WIDTH have no destination.
    assign wdata          = bus.wr_data[WIDTH-1:0];
    assign unused_wr_data = ^bus.wr_data;

    assign to_pad  = out_reg;
    assign pad_ena = oe_reg;

    // Two-flop synchronizer. sync_vld tracks how many real pad samples have
    // entered the pipe since reset, so edge detection never treats the
    // reset value of the flops as a previous pad level.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync1    <= '0;
            sync2    <= '0;
            sync_vld <= '0;
        end else begin
            sync1    <= from_pad;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] in_reg;
    logic [CW-1:0]    cnt [WIDTH];
    logic             seeded;

    // Per-bit debounce. The first valid synchronized sample after reset
    // seeds both candidate and accepted value, so the initial pad level is
    // never reported as an edge. Afterwards a change reloads the candidate
    // and restarts the count; IN follows the candidate on the edge where the
    // count reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cand   <= '0;
            in_reg <= '0;
            seeded <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (!seeded) begin
            if (sync_vld[1]) begin
                seeded <= 1'b1;
                cand   <= sync2;
                in_reg <= sync2;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != cand[i]) begin
                    cand[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                    if (cnt[i] == CNT_MAX - 1'b1) begin
                        in_reg[i] <= cand[i];
                    end
                end
            end
        end
    end

    assign in_val   = in_reg;
    assign in_valid = seeded;
`else
    assign in_val   = sync2;
    assign in_valid = sync_vld[1];
`endif

    // Edge history. prev_valid becomes 1 one cycle after IN first carries a
    // real pad level, which suppresses a false rise right after reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= in_val;
            prev_valid <= in_valid;
        end
    end

    always_comb begin
        rise    = '0;
        sts_clr = '0;
        if (prev_valid) begin
            rise = in_val & ~prev;
        end
        if (bus.wr_en && bus.addr == ADDR_STS) begin
            sts_clr = wdata;
        end
    end

    // CPU-writable registers. Status applies the W1C clear before OR-ing in
    // new rises, so a rise landing on the clearing edge survives.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_reg  <= '0;
            oe_reg   <= '0;
            mask_reg <= '0;
            sts_reg  <= '0;
        end else begin
            if (bus.wr_en && bus.addr == ADDR_OUT) begin
                out_reg <= wdata;
            end
            if (bus.wr_en && bus.addr == ADDR_OE) begin
                oe_reg <= wdata;
            end
            if (bus.wr_en && bus.addr == ADDR_MASK) begin
                mask_reg <= wdata;
            end
            sts_reg <= (sts_reg & ~sts_clr) | rise;
        end
    end

    // Read mux works on current register values, so a read that coincides
    // with a write to the same address returns the pre-write value.
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_OUT:  rd_mux = out_reg;
            ADDR_OE:   rd_mux = oe_reg;
            ADDR_IN:   rd_mux = in_val;
            ADDR_STS:  rd_mux = sts_reg;
            ADDR_MASK: rd_mux = mask_reg;
            default:   rd_mux = '0;
        endcase
    end

    // Read data is captured only on a read and held until the next one;
    // irq is registered from the current status and mask.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            irq          <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= 32'(rd_mux);
            end
            irq <= |(sts_reg & mask_reg);
        end
    end

endmodule
